alt_inv_deser: RTL and testbench

Serial receive-side decoder for the alternate-bit-inversion line code: even-indexed bits inverted, odd-indexed bits passed straight through. Accepts a framed bit stream one bit per strobe and assembles N-bit words LSB first. Undoes the even-bit inversion and presents each decoded word on a registered valid/ready output. Sits downstream of the serialiser that follows the parallel inverter stage, and feeds word-level consumers.

---
 rtl/alt_inv_deser_if.sv | 23 ++
 rtl/alt_inv_deser.sv | 83 ++++++++
 tb/tb_alt_inv_deser.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_inv_deser_if.sv
// Bit-stream input and decoded-word output handshake for alt_inv_deser.
interface alt_inv_deser_if #(
  parameter int unsigned N = 4
);
  logic         SIN;
  logic         SVALID;
  logic         START;
  logic [N-1:0] Y;
  logic         YVALID;
  logic         YREADY;
  logic         BUSY;
  logic         OVR;

  modport master (
    output SIN, SVALID, START, YREADY,
    input  Y, YVALID, BUSY, OVR
  );

  modport slave (
    input  SIN, SVALID, START, YREADY,
    output Y, YVALID, BUSY, OVR
  );
endinterface

// File: rtl/alt_inv_deser.sv
// Alternate-bit-inversion deserialiser: assembles N-bit words LSB first,
// undoes the even-bit inversion and holds each word on a valid/ready register.
module alt_inv_deser #(
  parameter int unsigned N = 4
) (
  input logic            CLK,
  input logic            RESET_N,
  alt_inv_deser_if.slave bus
);
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  function automatic logic [N-1:0] even_mask();
    logic [N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [N-1:0] MASK = even_mask();

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  // Bit N-1 of a word is never stored: it is taken straight from SIN on the completing bit.
  logic [N-2:0]    sr;
  logic [N-1:0]    y;
  logic            yvalid;
  logic            ovr;

  logic            done;
  logic [N-1:0]    decoded;

  always_comb begin
    done    = (state == SHIFT) && bus.SVALID && !bus.START && (cnt == CW'(N-1));
    decoded = {bus.SIN, sr} ^ MASK;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      y      <= '0;
      yvalid <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (bus.SVALID) begin
        if (bus.START) begin
          sr[0] <= bus.SIN;
          cnt   <= CW'(1);
          state <= SHIFT;
        end else if (state == SHIFT) begin
          if (done) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            for (int unsigned i = 0; i < N - 1; i++) begin
              if (cnt == CW'(i)) sr[i] <= bus.SIN;
            end
            cnt <= cnt + CW'(1);
          end
        end
      end

      if (done) begin
        if (!yvalid || bus.YREADY) begin
          y      <= decoded;
          yvalid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (yvalid && bus.YREADY) begin
        yvalid <= 1'b0;
      end
    end
  end

  assign bus.Y      = y;
  assign bus.YVALID = yvalid;
  assign bus.OVR    = ovr;
  assign bus.BUSY   = (state == SHIFT);
endmodule

// File: tb/tb_alt_inv_deser.sv
// Self-checking bench for alt_inv_deser: directed scenarios plus random traffic
// compared against a queue-based word-assembly model.
module tb_alt_inv_deser;
  localparam int unsigned N = 4;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alt_inv_deser_if #(.N(N)) bus ();
  alt_inv_deser #(.N(N)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: collected bits of the word in progress plus the output register.
  int           mq[$];
  logic [N-1:0] m_y;
  logic         m_valid;
  logic         m_ovr;

  function automatic logic [N-1:0] decode(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (i % 2 == 0) ? ~w[i] : w[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_y = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_update();
    logic         complete;
    logic [N-1:0] w;
    complete = 1'b0;
    w = '0;
    if (bus.SVALID) begin
      if (bus.START) begin
        mq.delete();
        mq.push_back(int'(bus.SIN));
      end else if (mq.size() > 0) begin
        mq.push_back(int'(bus.SIN));
        if (mq.size() == N) begin
          for (int i = 0; i < N; i++) w[i] = mq[i][0];
          mq.delete();
          complete = 1'b1;
        end
      end
    end
    if (complete) begin
      if (!m_valid || bus.YREADY) begin
        m_y = decode(w);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && bus.YREADY) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RESET_N) model_reset();
    else model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.SIN = 1'b0;
    bus.SVALID = 1'b0;
    bus.START = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    #3;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic send_word(input logic [N-1:0] enc, input int gap);
    for (int i = 0; i < N; i++) begin
      bus.SIN = enc[i];
      bus.SVALID = 1'b1;
      bus.START = (i == 0);
      tick();
      if (i < N - 1) begin
        for (int g = 0; g < gap; g++) begin
          idle_inputs();
          tick();
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.YREADY = 1'b1;
    RESET_N = 1'b0;
    model_reset();
    #3;
    checks++; if (bus.Y !== 4'h0) begin errors++; $display("FAIL reset_y: got %h want 0", bus.Y); end
    checks++; if (bus.YVALID !== 1'b0) begin errors++; $display("FAIL reset_yvalid: got %b want 0", bus.YVALID); end
    checks++; if (bus.OVR !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.OVR); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    tick();
    RESET_N = 1'b1;
    tick();
    checks++; if (bus.BUSY !== 1'b0 || bus.YVALID !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %b yvalid %b want 0 0", bus.BUSY, bus.YVALID); end
  endtask

  task automatic test_basic();
    logic [N-1:0] enc;
    bus.YREADY = 1'b1;
    enc = 4'hF;
    for (int i = 0; i < N; i++) begin
      bus.SIN = enc[i];
      bus.SVALID = 1'b1;
      bus.START = (i == 0);
      tick();
      if (i < N - 1) begin
        checks++; if (bus.YVALID !== 1'b0 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL basic_latency bit %0d: yvalid %b busy %b want 0 1", i, bus.YVALID, bus.BUSY); end
      end
    end
    idle_inputs();
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'hA) begin errors++; $display("FAIL basic_ones: yvalid %b y %h want 1 a", bus.YVALID, bus.Y); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", bus.BUSY); end
    tick();
    checks++; if (bus.YVALID !== 1'b0 || bus.Y !== 4'hA) begin errors++; $display("FAIL basic_one_cycle: yvalid %b y %h want 0 a", bus.YVALID, bus.Y); end
    send_word(4'h0, 0);
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'h5) begin errors++; $display("FAIL basic_zeros: yvalid %b y %h want 1 5", bus.YVALID, bus.Y); end
    send_word(4'b1010, 0);
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'hF) begin errors++; $display("FAIL basic_0101: yvalid %b y %h want 1 f", bus.YVALID, bus.Y); end
    tick();
  endtask

  task automatic test_gaps();
    logic [N-1:0] encs [3];
    logic [N-1:0] exps [3];
    int           busy_bad;
    encs = '{4'hF, 4'h0, 4'b1010};
    exps = '{4'hA, 4'h5, 4'hF};
    bus.YREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      busy_bad = 0;
      for (int i = 0; i < N; i++) begin
        bus.SIN = encs[k][i];
        bus.SVALID = 1'b1;
        bus.START = (i == 0);
        tick();
        if (i < N - 1) begin
          if (bus.BUSY !== 1'b1) busy_bad++;
          for (int g = 0; g < 3; g++) begin
            bus.SVALID = 1'b0;
            bus.START = 1'b0;
            bus.SIN = 1'($urandom);
            tick();
            if (bus.BUSY !== 1'b1) busy_bad++;
          end
        end
      end
      idle_inputs();
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL gaps_busy word %0d: %0d low cycles want 0", k, busy_bad); end
      checks++; if (bus.YVALID !== 1'b1 || bus.Y !== exps[k]) begin errors++; $display("FAIL gaps_word %0d: yvalid %b y %h want 1 %h", k, bus.YVALID, bus.Y, exps[k]); end
      tick();
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.YREADY = 1'b0;
    send_word(4'hF, 0);
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'hA || bus.OVR !== 1'b0) begin errors++; $display("FAIL ovr_first: yvalid %b y %h ovr %b want 1 a 0", bus.YVALID, bus.Y, bus.OVR); end
    send_word(4'h0, 0);
    checks++; if (bus.Y !== 4'hA || bus.YVALID !== 1'b1) begin errors++; $display("FAIL ovr_hold: yvalid %b y %h want 1 a", bus.YVALID, bus.Y); end
    checks++; if (bus.OVR !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", bus.OVR); end
    bus.YREADY = 1'b1;
    tick();
    checks++; if (bus.YVALID !== 1'b0 || bus.OVR !== 1'b1) begin errors++; $display("FAIL ovr_drain: yvalid %b ovr %b want 0 1", bus.YVALID, bus.OVR); end
  endtask

  task automatic test_simul_accept();
    logic [N-1:0] enc;
    do_reset();
    bus.YREADY = 1'b0;
    send_word(4'hF, 0);
    enc = 4'h0;
    for (int i = 0; i < N; i++) begin
      bus.SIN = enc[i];
      bus.SVALID = 1'b1;
      bus.START = (i == 0);
      bus.YREADY = (i == N - 1);
      tick();
    end
    idle_inputs();
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'h5 || bus.OVR !== 1'b0) begin errors++; $display("FAIL simul_accept: yvalid %b y %h ovr %b want 1 5 0", bus.YVALID, bus.Y, bus.OVR); end
    tick();
    checks++; if (bus.YVALID !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b want 0", bus.YVALID); end
  endtask

  task automatic test_abort();
    logic [N-1:0] enc;
    int           early;
    bus.YREADY = 1'b1;
    early = 0;
    for (int i = 0; i < 2; i++) begin
      bus.SIN = 1'b1;
      bus.SVALID = 1'b1;
      bus.START = (i == 0);
      tick();
      if (bus.YVALID !== 1'b0) early++;
    end
    enc = 4'b1010;
    for (int i = 0; i < N; i++) begin
      bus.SIN = enc[i];
      bus.SVALID = 1'b1;
      bus.START = (i == 0);
      tick();
      if (i < N - 1 && bus.YVALID !== 1'b0) early++;
    end
    idle_inputs();
    checks++; if (early != 0) begin errors++; $display("FAIL abort_no_output: %0d early valid cycles want 0", early); end
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'hF) begin errors++; $display("FAIL abort_word: yvalid %b y %h want 1 f", bus.YVALID, bus.Y); end
    tick();
    checks++; if (bus.YVALID !== 1'b0) begin errors++; $display("FAIL abort_extra: yvalid %b want 0", bus.YVALID); end
  endtask

  task automatic test_reset_midword();
    bus.YREADY = 1'b1;
    bus.SIN = 1'b1;
    bus.SVALID = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    idle_inputs();
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.BUSY !== 1'b0 || bus.YVALID !== 1'b0) begin errors++; $display("FAIL rst_mid: busy %b yvalid %b want 0 0", bus.BUSY, bus.YVALID); end
    tick();
    RESET_N = 1'b1;
    bus.YREADY = 1'b0;
    send_word(4'hF, 0);
    send_word(4'hF, 0);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.Y !== 4'h0 || bus.YVALID !== 1'b0 || bus.OVR !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_valid: y %h yvalid %b ovr %b busy %b want 0 0 0 0", bus.Y, bus.YVALID, bus.OVR, bus.BUSY); end
    tick();
    RESET_N = 1'b1;
    bus.YREADY = 1'b1;
    send_word(4'h0, 0);
    checks++; if (bus.YVALID !== 1'b1 || bus.Y !== 4'h5) begin errors++; $display("FAIL rst_recover: yvalid %b y %h want 1 5", bus.YVALID, bus.Y); end
    tick();
  endtask

  task automatic test_random();
    int bad;
    int words;
    bad = 0;
    words = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 500 == 250) begin
        idle_inputs();
        do_reset();
      end
      bus.SVALID = ($urandom_range(0, 9) < 7);
      bus.START = ($urandom_range(0, 9) < 2);
      bus.SIN = 1'($urandom);
      bus.YREADY = 1'($urandom);
      tick();
      if (m_valid) words++;
      if (bus.YVALID !== m_valid || bus.OVR !== m_ovr || bus.BUSY !== (mq.size() > 0)
          || (m_valid && bus.Y !== m_y)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random cycle %0d: y %h v %b ovr %b busy %b want y %h v %b ovr %b busy %b",
                   c, bus.Y, bus.YVALID, bus.OVR, bus.BUSY, m_y, m_valid, m_ovr, mq.size() > 0);
      end
    end
    idle_inputs();
    checks++; if (bad != 0) begin errors++; $display("FAIL random_model: %0d mismatching cycles want 0", bad); end
    checks++; if (words == 0) begin errors++; $display("FAIL random_coverage: %0d valid cycles want >0", words); end
  endtask

  initial begin
    idle_inputs();
    bus.YREADY = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_simul_accept();
    test_abort();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
